// File: rtl/fread_responder_if.sv
// Request/response/image-write bundle between an fread initiator and its responder.
interface fread_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_offset;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    output req_valid, req_offset, resp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, resp_data, resp_valid
  );

  modport slave (
    input  req_valid, req_offset, resp_ready, wr_en, wr_addr, wr_data,
    output req_ready, resp_data, resp_valid
  );
endinterface

// File: rtl/fread_responder.sv
// fread target: serves CHUNK_LEN-byte chunks from a 32 KiB SPRAM byte image over valid/ready.
// Optional macro FREAD_RESP_ERASED_FILL_EN: bytes beyond the image read as 8'hFF instead of wrapping.

// Behavioural stand-in for one SB_SPRAM256KA (16384 x 16, nibble write mask, registered read).
module fread_spram (
  input  logic        clk,
  input  logic [13:0] address,
  input  logic [15:0] data_in,
  input  logic [3:0]  mask_wren,
  input  logic        wren,
  input  logic        chip_select,
  input  logic        standby,
  input  logic        sleep,
  input  logic        power_off,
  output logic [15:0] data_out
);
  logic [15:0] mem [16384];
  logic        active;

  // power_off is active-low on the real macro
  assign active = chip_select && !standby && !sleep && power_off;

  always_ff @(posedge clk) begin
    if (active) begin
      if (wren) begin
        for (int i = 0; i < 4; i++) begin
          if (mask_wren[i]) mem[address][i*4 +: 4] <= data_in[i*4 +: 4];
        end
      end else begin
        data_out <= mem[address];
      end
    end
  end
endmodule

// state | meaning
// IDLE  | req_ready high; image writes accepted
// FETCH | word address presented to SPRAM
// LOAD  | SPRAM word captured, first byte of the word registered
// SEND  | byte held on resp_data until resp_ready
module fread_responder #(
  parameter int CHUNK_LEN = 2048,
  parameter int IMG_BYTES = 32768
) (
  input  logic               clk,
  input  logic               rst_n,
  fread_responder_if.slave   bus,
  output logic               busy
);
  localparam int IMG_AW = $clog2(IMG_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [12:0] rem_q, rem_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  logic [13:0] sp_addr;
  logic        sp_wren;
  logic [15:0] sp_dout;
  logic        erased;

`ifdef FREAD_RESP_ERASED_FILL_EN
  assign erased = (addr_q >= 32'(IMG_BYTES));
`else
  assign erased = 1'b0;
`endif

  function automatic logic [7:0] pick(input logic [15:0] w, input logic hi, input logic fill);
    if (fill) return 8'hFF;
    return hi ? w[15:8] : w[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    data_d  = data_q;
    valid_d = valid_q;
    sp_addr = addr_q[IMG_AW-1:1];
    sp_wren = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a write and an acceptance in the same cycle both proceed; FETCH follows the write
        if (rst_n && bus.wr_en) begin
          sp_addr = bus.wr_addr;
          sp_wren = 1'b1;
        end
        if (rst_n && bus.req_valid) begin
          addr_d  = bus.req_offset;
          rem_d   = 13'(CHUNK_LEN);
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        word_d  = sp_dout;
        data_d  = pick(sp_dout, addr_q[0], erased);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.resp_ready) begin
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 13'd1;
          if (rem_q == 13'd1) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else if (!addr_q[0]) begin
            // odd partner of an even byte shares both the word and the erased status
            data_d = pick(word_q, 1'b1, erased);
          end else begin
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  fread_spram u_spram (
    .clk         (clk),
    .address     (sp_addr),
    .data_in     (bus.wr_data),
    .mask_wren   (4'b1111),
    .wren        (sp_wren),
    .chip_select (1'b1),
    .standby     (1'b0),
    .sleep       (1'b0),
    .power_off   (1'b1),
    .data_out    (sp_dout)
  );

  assign bus.req_ready  = rst_n && (state_q == S_IDLE);
  assign bus.resp_data  = data_q;
  assign bus.resp_valid = valid_q;
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_fread_responder.sv
// Scoreboard bench for fread_responder: random image, directed and random chunk requests.
module tb_fread_responder;
  localparam int CHUNK = 5;

  typedef struct {
    logic [7:0] b;
    int         t;
    bit         timed;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   ready_mode = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [7:0] img [32768];

  fread_responder_if bus ();

  fread_responder #(.CHUNK_LEN(CHUNK), .IMG_BYTES(32768)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d: bound expired", name, cyc);
  endtask

  // Reference: a byte at a 32-bit offset is the image byte at offset mod 32 KiB,
  // or erased flash when the fill option is built in and the offset is past the image.
  function automatic logic [7:0] exp_byte(input logic [31:0] a);
`ifdef FREAD_RESP_ERASED_FILL_EN
    if (a >= 32'd32768) return 8'hFF;
`endif
    return img[a[14:0]];
  endfunction

  function automatic void model_write(input logic [13:0] w, input logic [15:0] d);
    img[{w, 1'b0}] = d[7:0];
    img[{w, 1'b1}] = d[15:8];
  endfunction

  // resp_ready patterns: 0 always ready, 1 repeating 1,0,0, 2 random
  initial begin
    int ph = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.resp_ready = 1'b1;
        1: begin bus.resp_ready = (ph % 3 == 0); ph++; end
        default: bus.resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: stability, status and scoreboard comparison on every handshake
  initial begin
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    int         vstart = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        pr = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("stall_valid", 32'(bus.resp_valid), 32'd1);
        check("stall_data", 32'(bus.resp_data), 32'(pd));
      end
      if (bus.resp_valid && (!pv || pr)) vstart = cyc;
      check("busy", 32'(busy), 32'(q.size() != 0));
      check("req_ready", 32'(bus.req_ready), 32'(q.size() == 0));
      if (bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) begin
          fail_now("unexpected_byte");
        end else begin
          e = q.pop_front();
          check("resp_data", 32'(bus.resp_data), 32'(e.b));
          if (e.timed) check("byte_cycle", 32'(vstart), 32'(e.t));
        end
      end
      pv = bus.resp_valid;
      pr = bus.resp_ready;
      pd = bus.resp_data;
    end
  end

  task automatic req_accept(input logic [31:0] off, input int mode, input bit with_wr,
                            input logic [13:0] wa, input logic [15:0] wd);
    int         acc;
    int         guard;
    int         t;
    logic [31:0] a;
    exp_t       e;
    ready_mode = mode;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_offset = off;
    if (with_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = wa;
      bus.wr_data = wd;
    end
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      guard++;
      if (guard > 200) begin
        fail_now("req_accept");
        bus.req_valid = 1'b0;
        bus.wr_en     = 1'b0;
        return;
      end
    end
    acc = cyc;
    if (with_wr) model_write(wa, wd);
    @(posedge clk);
    t = acc + 3;
    for (int i = 0; i < CHUNK; i++) begin
      a = off + 32'(i);
      e.b = exp_byte(a);
      e.t = t;
      e.timed = (mode == 0) || (i == 0);
      q.push_back(e);
      t = t + (a[0] ? 3 : 1);
    end
    #1;
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        fail_now("drain");
        q.delete();
      end
    end
    @(posedge clk);
  endtask

  task automatic issue_req(input logic [31:0] off, input int mode);
    req_accept(off, mode, 1'b0, 14'd0, 16'd0);
    drain();
  endtask

  initial begin
    logic [31:0] off;
    int          guard;
    bus.req_valid  = 1'b0;
    bus.req_offset = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fill the whole image, then the four directed words
    for (int w = 0; w < 16384; w++) begin
      @(posedge clk);
      #1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 14'(w);
      bus.wr_data = (w < 4) ? 16'((2 * w + 2) * 16'h1111 + 16'h1100 - 16'h1100 + 16'h0) : 16'($urandom);
      model_write(bus.wr_addr, bus.wr_data);
    end
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    model_write(14'd0, 16'h2211);
    model_write(14'd1, 16'h4433);
    model_write(14'd2, 16'h6655);
    model_write(14'd3, 16'h8877);
    for (int w = 0; w < 4; w++) begin
      @(posedge clk);
      #1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 14'(w);
      bus.wr_data = {img[2*w+1], img[2*w]};
    end
    @(posedge clk);
    #1 bus.wr_en = 1'b0;

    issue_req(32'd0, 0);
    issue_req(32'd1, 0);
    issue_req(32'd0, 1);
    issue_req(32'd32767, 0);
    issue_req(32'hFFFF_FFFE, 0);

    // write while busy must be dropped
    req_accept(32'd40, 0, 1'b0, 14'd0, 16'd0);
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 14'd0;
    bus.wr_data = 16'hDEAD;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    drain();
    issue_req(32'd0, 0);

    // write coinciding with acceptance is visible to that request
    req_accept(32'd2, 0, 1'b1, 14'd1, 16'hBEEF);
    drain();

    // reset during the second byte of a chunk
    req_accept(32'd8, 0, 1'b0, 14'd0, 16'd0);
    guard = 0;
    while (q.size() > CHUNK - 1 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 50) fail_now("first_byte_wait");
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_data", 32'(bus.resp_data), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue_req(32'd6, 2);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: off = $urandom;
        1: off = 32'($urandom_range(0, 32767));
        2: off = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        default: off = 32'd32768 - 32'($urandom_range(0, 6));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        req_accept(off, $urandom_range(0, 2), 1'b1, 14'($urandom), 16'($urandom));
        drain();
      end else begin
        issue_req(off, $urandom_range(0, 2));
      end
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fread_responder.md
# fread_responder

Target-side model of the fread request/response stream: accepts chunk requests (32-bit byte offset, valid/ready) and returns CHUNK_LEN bytes from an SB_SPRAM256KA-backed 32 KiB byte image over a valid/ready byte stream. It sits opposite an fread initiator: in simulation it stands in for the ESP32 file server, and on-chip it serves images preloaded through a word write port. The image is stored as 16-bit words, two bytes per word, little-endian.

## Interface
- CHUNK_LEN, 2048: bytes returned per accepted request; 1..4096.
- IMG_BYTES, 32768: image capacity in bytes; fixed by one SPRAM (16384 x 16).
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready.
- req_offset  in  32  byte offset of chunk start; sampled on acceptance.
- resp_data  out  8  response byte.
- resp_valid  out  1  resp_data valid; held with stable data until resp_ready.
- resp_ready  in  1  consumer accepts byte on resp_valid & resp_ready.
- wr_en  in  1  image write strobe.
- wr_addr  in  14  word address.
- wr_data  in  16  word; [7:0] = even byte, [15:8] = odd byte.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, LOAD, SEND.
- IDLE: req_ready=1. On acceptance: addr <= req_offset, remaining <= CHUNK_LEN, go FETCH.
- FETCH: SPRAM ADDRESS = addr[14:1], WREN=0; go LOAD.
- LOAD: capture SPRAM DATAOUT into word register; resp_data <= addr[0] ? word[15:8] : word[7:0]; resp_valid <= 1; go SEND.
- SEND: wait for resp_ready. On handshake: addr <= addr+1, remaining <= remaining-1.
  - remaining was 1: resp_valid <= 0, go IDLE.
  - addr was even: stay SEND, resp_data <= held word[15:8] (no SPRAM access).
  - addr was odd: resp_valid <= 0, go FETCH.
- addr is 32-bit and wraps 0xFFFFFFFF -> 0; remaining is 13-bit.
- Writes: wr_en in IDLE writes wr_data to wr_addr (MASKWREN 4'b1111). wr_en while busy is dropped; no SPRAM write occurs.
- Simultaneous wr_en and accepted req_valid in IDLE: write completes this cycle, request accepted this cycle; the first FETCH sees the new data.
- SPRAM: CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1.

## Timing
- Reset values: req_ready=0 during reset then 1 in IDLE; resp_valid=0; resp_data=8'h00; busy=0; state IDLE. SPRAM contents are not cleared.
- Reset mid-chunk: next cycle state IDLE, resp_valid=0; the remainder of the chunk is discarded.
- Request accepted at cycle T: FETCH at T+1, LOAD at T+2, first resp_valid=1 at T+3.
- With resp_ready held high and even start offset: even/odd byte pairs on consecutive cycles, then a 2-cycle gap (2 bytes per 4 cycles).
- Odd start offset: first byte is the high byte of its word; the next byte refetches.
- resp_data and resp_valid come directly from registers; no combinational path from resp_ready.

## Configuration
- FREAD_RESP_ERASED_FILL_EN defined: a byte with addr >= IMG_BYTES returns 8'hFF (erased flash). FETCH/LOAD timing is unchanged; SPRAM data is ignored for that byte.
- Not defined: the address is taken modulo IMG_BYTES (addr[14:0]), so the image repeats across the offset space.

## Test plan
- Load words 0..3 = 16'h2211, 16'h4433, 16'h6655, 16'h8877; CHUNK_LEN=8, offset 0, resp_ready=1 -> bytes 11 22 33 44 55 66 77 88; first resp_valid 3 cycles after acceptance; busy low after the last handshake.
- Same image, offset 1, CHUNK_LEN=3 -> bytes 22 33 44; req_ready low until the third handshake completes.
- resp_ready toggling 1,0,0,1,... -> resp_data stable while stalled; no byte lost or duplicated.
- With the macro: offset 32767, CHUNK_LEN=3 -> last image byte, FF, FF. Without the macro: last image byte, 11, 22.
- wr_en to word 0 while busy -> word 0 unchanged on the next request; wr_en together with an accepted request in IDLE -> the new word is returned.
- rst_n low during the 2nd byte of a chunk -> resp_valid=0 next cycle; a new request returns the correct bytes from its own offset.
